proj_sort_ctrl: RTL and testbench

PROJ_SORT_CTRL -- requirements
Module: proj_sort_ctrl

---
 rtl/proj_sort_ctrl.sv | 142 ++++++++++++++
 tb/tb_proj_sort_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_sort_ctrl.sv
// Sort controller: streams (signature, index) pairs into proj_sorter, flushes at
// end of document, captures the smallest indices and holds them for downstream.
package proj_pkg;
  localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
  localparam int INDICE_LEN                    = 16;
  localparam int HASHER_SORTER_SIGNATURE       = 32;
endpackage

module proj_sort_ctrl #(
  parameter int INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
  parameter int INDICE_LEN    = proj_pkg::INDICE_LEN,
  parameter int SIGNATURE_LEN = proj_pkg::HASHER_SORTER_SIGNATURE,
  parameter int CNT_LEN       = 16,
  parameter int VALID_TIMEOUT = 4
) (
  input  logic                                in_clk,
  input  logic                                in_rst,
  input  logic [SIGNATURE_LEN-1:0]            in_signature,
  input  logic [INDICE_LEN-1:0]               in_index,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                out_accept,
  output logic [SIGNATURE_LEN-1:0]            srt_signature,
  output logic [INDICE_LEN-1:0]               srt_index,
  output logic                                srt_end_sorting,
  output logic                                srt_rst_n,
  input  logic                                srt_sort_valid,
  input  logic [INDICES_COUNT*INDICE_LEN-1:0] srt_smallest_idx,
  output logic [INDICES_COUNT*INDICE_LEN-1:0] out_idx,
  output logic [CNT_LEN-1:0]                  out_count,
  output logic                                out_underfill,
  output logic                                out_err,
  output logic                                out_valid,
  input  logic                                in_ack
);

  localparam int WAIT_W = (VALID_TIMEOUT > 1) ? $clog2(VALID_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(VALID_TIMEOUT - 1);
  localparam logic [CNT_LEN-1:0] CNT_MAX   = '1;
  localparam logic [CNT_LEN:0]   IDX_CNT   = (CNT_LEN + 1)'(INDICES_COUNT);

  typedef enum logic [1:0] {
    CLEAR,
    STREAM,
    FLUSH,
    HOLD
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic                last_pend;
  logic [CNT_LEN-1:0]  cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                xfer;
  logic                capture;
  logic                timeout;

  assign xfer = in_valid && out_accept;

  always_ff @(posedge in_clk) begin
    if (in_rst) state <= CLEAR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    out_accept      = 1'b0;
    srt_rst_n       = 1'b1;
    srt_end_sorting = 1'b0;
    out_valid       = 1'b0;
    capture         = 1'b0;
    timeout         = 1'b0;
    case (state)
      CLEAR: begin
        srt_rst_n = 1'b0;
        state_nx  = STREAM;
      end
      STREAM: begin
        // last element still sits on srt_* for one cycle before the flush
        out_accept = !last_pend;
        if (last_pend) state_nx = FLUSH;
      end
      FLUSH: begin
        srt_end_sorting = 1'b1;
        if (srt_sort_valid) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end else if (wait_cnt == WAIT_LAST) begin
          capture  = 1'b1;
          timeout  = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (in_ack) state_nx = CLEAR;
      end
      default: state_nx = CLEAR;
    endcase
    // reset forces the handshake outputs quiet even before the state register clears
    if (in_rst) begin
      out_accept      = 1'b0;
      srt_rst_n       = 1'b0;
      srt_end_sorting = 1'b0;
      out_valid       = 1'b0;
      capture         = 1'b0;
      timeout         = 1'b0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      srt_signature <= '1;
      srt_index     <= '0;
      last_pend     <= 1'b0;
      cnt           <= '0;
      wait_cnt      <= '0;
      out_idx       <= '0;
      out_count     <= '0;
      out_underfill <= 1'b0;
      out_err       <= 1'b0;
    end else begin
      srt_signature <= xfer ? in_signature : '1;
      srt_index     <= xfer ? in_index : '0;
      if (state == CLEAR) begin
        cnt       <= '0;
        last_pend <= 1'b0;
      end else if (xfer) begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_LEN'(1);
        last_pend <= in_last;
      end
      wait_cnt <= (state == FLUSH) ? wait_cnt + WAIT_W'(1) : '0;
      if (capture) begin
        out_idx       <= srt_smallest_idx;
        out_count     <= cnt;
        out_underfill <= ({1'b0, cnt} < IDX_CNT);
        out_err       <= timeout;
      end
    end
  end

endmodule

// File: tb/tb_proj_sort_ctrl.sv
// Bench for proj_sort_ctrl: a behavioural sorter stub answers the srt_* side,
// and results are compared against a selection-based reference model.
module tb_proj_sort_ctrl;
  localparam int IC = 4;
  localparam int IL = 16;
  localparam int SL = 32;
  localparam int CL = 16;
  localparam int VT = 4;

  logic              clk = 1'b0;
  logic              in_rst = 1'b1;
  logic [SL-1:0]     in_signature = '0;
  logic [IL-1:0]     in_index = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              out_accept;
  logic [SL-1:0]     srt_signature;
  logic [IL-1:0]     srt_index;
  logic              srt_end_sorting;
  logic              srt_rst_n;
  logic              srt_sort_valid;
  logic [IC*IL-1:0]  srt_smallest_idx;
  logic [IC*IL-1:0]  out_idx;
  logic [CL-1:0]     out_count;
  logic              out_underfill;
  logic              out_err;
  logic              out_valid;
  logic              in_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  proj_sort_ctrl #(
    .INDICES_COUNT(IC), .INDICE_LEN(IL), .SIGNATURE_LEN(SL),
    .CNT_LEN(CL), .VALID_TIMEOUT(VT)
  ) dut (
    .in_clk(clk), .in_rst(in_rst), .in_signature(in_signature), .in_index(in_index),
    .in_valid(in_valid), .in_last(in_last), .out_accept(out_accept),
    .srt_signature(srt_signature), .srt_index(srt_index),
    .srt_end_sorting(srt_end_sorting), .srt_rst_n(srt_rst_n),
    .srt_sort_valid(srt_sort_valid), .srt_smallest_idx(srt_smallest_idx),
    .out_idx(out_idx), .out_count(out_count), .out_underfill(out_underfill),
    .out_err(out_err), .out_valid(out_valid), .in_ack(in_ack)
  );

  // sorter stub: keeps every non-filler pair in signature order
  typedef struct packed {
    logic [SL-1:0] sig;
    logic [IL-1:0] idx;
  } elem_t;
  elem_t            sq[$];
  logic             sorter_en = 1'b1;
  logic [IC*IL-1:0] stub_idx = '0;

  assign srt_sort_valid   = srt_end_sorting && sorter_en;
  assign srt_smallest_idx = stub_idx;

  always @(posedge clk) begin
    int p;
    elem_t e;
    logic [IC*IL-1:0] v;
    if (!srt_rst_n) sq.delete();
    else if (srt_signature != '1) begin
      e.sig = srt_signature;
      e.idx = srt_index;
      p = 0;
      while (p < sq.size() && sq[p].sig <= srt_signature) p++;
      sq.insert(p, e);
    end
    v = '0;
    for (int k = 0; k < IC; k++) if (k < sq.size()) v[k*IL +: IL] = sq[k].idx;
    stub_idx <= v;
  end

  logic [SL-1:0] doc_sig[64];
  logic [IL-1:0] doc_idx[64];

  function automatic logic [IC*IL-1:0] model_idx(input int n);
    logic [IC*IL-1:0] r;
    bit used[64];
    int best;
    r = '0;
    foreach (used[j]) used[j] = 1'b0;
    for (int k = 0; k < IC && k < n; k++) begin
      best = -1;
      for (int j = 0; j < n; j++)
        if (!used[j] && (best < 0 || doc_sig[j] < doc_sig[best])) best = j;
      used[best] = 1'b1;
      r[k*IL +: IL] = doc_idx[best];
    end
    return r;
  endfunction

  function automatic logic [IC*IL-1:0] model_mask(input int n);
    logic [IC*IL-1:0] r;
    r = '0;
    for (int k = 0; k < IC && k < n; k++) r[k*IL +: IL] = '1;
    return r;
  endfunction

  task automatic gen_doc(input int n, input int unsigned slo, input int unsigned shi,
                         input int unsigned ilo, input int unsigned ihi);
    for (int i = 0; i < n; i++) begin
      bit dup;
      do begin
        doc_sig[i] = $urandom_range(shi, slo);
        dup = 1'b0;
        for (int j = 0; j < i; j++) if (doc_sig[j] == doc_sig[i]) dup = 1'b1;
      end while (dup);
      doc_idx[i] = IL'($urandom_range(ihi, ilo));
    end
  endtask

  // returns right after the edge that accepted the final element
  task automatic send_doc(input int n, input int gap_pct, input bit with_last, output bit ok);
    int i;
    int guard;
    bit acc;
    bit pending;
    i = 0; guard = 0; ok = 1'b1; pending = 1'b0;
    while (i < n) begin
      @(negedge clk);
      if (!pending && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end else begin
        in_valid     = 1'b1;
        in_signature = doc_sig[i];
        in_index     = doc_idx[i];
        in_last      = with_last && (i == n - 1);
      end
      acc = out_accept;
      @(posedge clk);
      if (in_valid && acc) begin
        i++;
        pending = 1'b0;
      end else pending = in_valid;
      guard++;
      if (guard > 1000) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_result(input bit keep_valid, output int lat, output int endc);
    lat = 0; endc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!keep_valid) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      if (srt_end_sorting) endc++;
      if (out_valid) begin
        lat = c;
        return;
      end
    end
    lat = -1;
  endtask

  task automatic do_ack();
    @(negedge clk);
    in_ack = 1'b1;
    @(negedge clk);
    in_ack = 1'b0;
  endtask

  task automatic test_reset();
    in_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_accept !== 1'b0) begin failures++; $display("FAIL reset_out_accept got=%0b exp=0", out_accept); end
    checks++; if (srt_end_sorting !== 1'b0) begin failures++; $display("FAIL reset_end_sorting got=%0b exp=0", srt_end_sorting); end
    checks++; if (srt_rst_n !== 1'b0) begin failures++; $display("FAIL reset_srt_rst_n got=%0b exp=0", srt_rst_n); end
    checks++; if (srt_signature !== '1) begin failures++; $display("FAIL reset_srt_signature got=%h exp=all-ones", srt_signature); end
    checks++; if (srt_index !== '0) begin failures++; $display("FAIL reset_srt_index got=%h exp=0", srt_index); end
    checks++; if (out_idx !== '0) begin failures++; $display("FAIL reset_out_idx got=%h exp=0", out_idx); end
    checks++; if (out_count !== '0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    checks++; if (out_underfill !== 1'b0 || out_err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", out_underfill, out_err); end
    in_rst = 1'b0;
    #1;
    checks++; if (srt_rst_n !== 1'b0 || out_accept !== 1'b0) begin failures++; $display("FAIL reset_clear_cycle got=rst_n%0b acc%0b exp=rst_n0 acc0", srt_rst_n, out_accept); end
    @(negedge clk);
    checks++; if (srt_rst_n !== 1'b1 || out_accept !== 1'b1) begin failures++; $display("FAIL reset_stream got=rst_n%0b acc%0b exp=rst_n1 acc1", srt_rst_n, out_accept); end
  endtask

  task automatic test_ten();
    bit ok;
    int lat, endc;
    logic [IC*IL-1:0] exp;
    for (int k = 0; k < 10; k++) begin
      doc_sig[k] = SL'((10 - k) * 32'h10101010);
      doc_idx[k] = IL'(10 - k);
    end
    exp = {16'd4, 16'd3, 16'd2, 16'd1};
    send_doc(10, 0, 1'b1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ten_send got=timeout exp=accepted"); end
    wait_result(1'b0, lat, endc);
    checks++; if (lat != 3) begin failures++; $display("FAIL ten_latency got=%0d exp=3", lat); end
    checks++; if (endc != 1) begin failures++; $display("FAIL ten_end_sorting_cycles got=%0d exp=1", endc); end
    checks++; if (out_idx !== exp) begin failures++; $display("FAIL ten_idx got=%h exp=%h", out_idx, exp); end
    checks++; if (out_count !== CL'(10)) begin failures++; $display("FAIL ten_count got=%0d exp=10", out_count); end
    checks++; if (out_underfill !== 1'b0 || out_err !== 1'b0) begin failures++; $display("FAIL ten_flags got=uf%0b err%0b exp=uf0 err0", out_underfill, out_err); end
    do_ack();
  endtask

  task automatic test_two();
    bit ok;
    int lat, endc;
    logic [IC*IL-1:0] exp, msk;
    doc_sig[0] = 32'd5; doc_idx[0] = 16'd7;
    doc_sig[1] = 32'd3; doc_idx[1] = 16'd9;
    exp = {16'd0, 16'd0, 16'd7, 16'd9};
    msk = model_mask(2);
    send_doc(2, 0, 1'b1, ok);
    wait_result(1'b0, lat, endc);
    checks++; if (lat != 3) begin failures++; $display("FAIL two_latency got=%0d exp=3", lat); end
    checks++; if ((out_idx & msk) !== exp) begin failures++; $display("FAIL two_idx got=%h exp=%h", out_idx & msk, exp); end
    checks++; if (out_count !== CL'(2) || out_underfill !== 1'b1) begin failures++; $display("FAIL two_count got=%0d uf%0b exp=2 uf1", out_count, out_underfill); end
    do_ack();
  endtask

  task automatic test_hold_stall();
    bit ok;
    int lat, endc;
    logic [IC*IL-1:0] exp;
    gen_doc(6, 1, 32'hFFFF_FFFE, 0, 16'hFFFF);
    exp = model_idx(6);
    send_doc(6, 0, 1'b1, ok);
    wait_result(1'b0, lat, endc);
    checks++; if (lat != 3) begin failures++; $display("FAIL hold_latency got=%0d exp=3", lat); end
    for (int c = 0; c < 20; c++) begin
      in_valid     = 1'b1;
      in_signature = SL'($urandom);
      in_index     = IL'($urandom);
      in_last      = 1'($urandom_range(1));
      @(negedge clk);
      checks++; if (out_accept !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL hold_handshake c=%0d got=acc%0b vld%0b exp=acc0 vld1", c, out_accept, out_valid); end
      checks++; if (out_idx !== exp || out_count !== CL'(6)) begin failures++; $display("FAIL hold_stable c=%0d got=%h/%0d exp=%h/6", c, out_idx, out_count, exp); end
      checks++; if (srt_signature !== '1 || srt_index !== '0) begin failures++; $display("FAIL hold_filler c=%0d got=%h/%h exp=all-ones/0", c, srt_signature, srt_index); end
    end
    do_ack();
    checks++; if (srt_rst_n !== 1'b0 || out_accept !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL hold_clear got=rst_n%0b acc%0b vld%0b exp=0 0 0", srt_rst_n, out_accept, out_valid); end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    checks++; if (srt_rst_n !== 1'b1 || out_accept !== 1'b1) begin failures++; $display("FAIL hold_stream got=rst_n%0b acc%0b exp=1 1", srt_rst_n, out_accept); end
  endtask

  task automatic test_timeout();
    bit ok;
    int lat, endc;
    sorter_en = 1'b0;
    gen_doc(3, 1, 32'hFFFF_FFFE, 0, 16'hFFFF);
    send_doc(3, 0, 1'b1, ok);
    wait_result(1'b0, lat, endc);
    checks++; if (endc != VT) begin failures++; $display("FAIL timeout_end_cycles got=%0d exp=%0d", endc, VT); end
    checks++; if (lat != 2 + VT) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, 2 + VT); end
    checks++; if (out_err !== 1'b1 || out_count !== CL'(3)) begin failures++; $display("FAIL timeout_err got=err%0b cnt%0d exp=err1 cnt3", out_err, out_count); end
    sorter_en = 1'b1;
    do_ack();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat, endc;
    logic [IC*IL-1:0] exp;
    gen_doc(10, 1, 1000, 16'h0100, 16'h01FF);
    send_doc(5, 0, 1'b0, ok);
    @(negedge clk);
    in_valid = 1'b0;
    in_rst   = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", out_valid); end
    in_rst = 1'b0;
    #1;
    checks++; if (srt_rst_n !== 1'b0 || out_accept !== 1'b0) begin failures++; $display("FAIL rstmid_clear got=rst_n%0b acc%0b exp=0 0", srt_rst_n, out_accept); end
    gen_doc(4, 100000, 32'h7FFF_FFFF, 16'h8000, 16'hFFFF);
    exp = model_idx(4);
    send_doc(4, 0, 1'b1, ok);
    wait_result(1'b0, lat, endc);
    checks++; if (out_idx !== exp || out_count !== CL'(4)) begin failures++; $display("FAIL rstmid_result got=%h/%0d exp=%h/4", out_idx, out_count, exp); end
    checks++; if (out_underfill !== 1'b0 || out_err !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=uf%0b err%0b exp=0 0", out_underfill, out_err); end
    do_ack();
  endtask

  task automatic test_random_gaps();
    int lens[6] = '{20, 1, 7, 20, 4, 3};
    bit ok;
    int lat, endc, n;
    logic [IC*IL-1:0] exp, msk;
    foreach (lens[d]) begin
      n = lens[d];
      gen_doc(n, 1, 32'hFFFF_FFFE, 0, 16'hFFFF);
      exp = model_idx(n);
      msk = model_mask(n);
      send_doc(n, 50, 1'b1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rand_send d=%0d got=timeout exp=accepted", d); end
      wait_result(1'b0, lat, endc);
      checks++; if (lat != 3) begin failures++; $display("FAIL rand_latency d=%0d got=%0d exp=3", d, lat); end
      checks++; if ((out_idx & msk) !== exp) begin failures++; $display("FAIL rand_idx d=%0d got=%h exp=%h", d, out_idx & msk, exp); end
      checks++; if (out_count !== CL'(n)) begin failures++; $display("FAIL rand_count d=%0d got=%0d exp=%0d", d, out_count, n); end
      checks++; if (out_underfill !== (n < IC) || out_err !== 1'b0) begin failures++; $display("FAIL rand_flags d=%0d got=uf%0b err%0b exp=uf%0b err0", d, out_underfill, out_err, n < IC); end
      do_ack();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat, endc, gap, vat;
    logic [IC*IL-1:0] exp_a, exp_b, got_a;
    in_ack = 1'b1;
    gen_doc(5, 1, 32'hFFFF_FFFE, 0, 16'hFFFF);
    exp_a = model_idx(5);
    send_doc(5, 0, 1'b1, ok);
    gap = -1; vat = -1; got_a = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (out_valid) begin
        vat = c;
        got_a = out_idx;
      end
      if (out_accept) begin
        gap = c;
        break;
      end
    end
    checks++; if (vat != 3) begin failures++; $display("FAIL b2b_valid_cycle got=%0d exp=3", vat); end
    checks++; if (got_a !== exp_a) begin failures++; $display("FAIL b2b_idx_a got=%h exp=%h", got_a, exp_a); end
    checks++; if (gap != 5) begin failures++; $display("FAIL b2b_gap got=%0d exp=5", gap); end
    gen_doc(8, 1, 32'hFFFF_FFFE, 0, 16'hFFFF);
    exp_b = model_idx(8);
    send_doc(8, 0, 1'b1, ok);
    wait_result(1'b0, lat, endc);
    checks++; if (lat != 3 || out_idx !== exp_b) begin failures++; $display("FAIL b2b_idx_b got=%h lat=%0d exp=%h lat=3", out_idx, lat, exp_b); end
    @(negedge clk);
    in_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ten();
    test_two();
    test_hold_stall();
    test_timeout();
    test_reset_mid();
    test_random_gaps();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=time-limit exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
